// File: rtl/frame_pkg.sv
// Shared constants, opcodes and FSM encoding for the display RAM write controller.
package frame_pkg;

  localparam int unsigned IMG_W = 64;
  localparam int unsigned IMG_H = 64;
  localparam int unsigned AW    = 12;
  localparam int unsigned CW    = 6;

  localparam logic [1:0] OP_SET_PIXEL = 2'b00;
  localparam logic [1:0] OP_HLINE     = 2'b01;
  localparam logic [1:0] OP_RECT      = 2'b10;
  localparam logic [1:0] OP_CLEAR     = 2'b11;

  typedef enum logic [1:0] {
    StIdle   = 2'b00,
    StDraw   = 2'b01,
    StFinish = 2'b10
  } state_t;

  function automatic logic [CW-1:0] min_c(input logic [CW-1:0] a, input logic [CW-1:0] b);
    return (a < b) ? a : b;
  endfunction

  function automatic logic [CW-1:0] max_c(input logic [CW-1:0] a, input logic [CW-1:0] b);
    return (a < b) ? b : a;
  endfunction

endpackage

// File: rtl/rect_scanner.sv
// Raster walker over [xs..xe] x [ys..ye]; holds the most recently issued pixel and
// presents the following pixel so the caller can issue it in the same cycle it steps.
module rect_scanner #(
  parameter int unsigned CW = 6
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_start,
  input  logic          i_step,
  input  logic [CW-1:0] i_xs,
  input  logic [CW-1:0] i_xe,
  input  logic [CW-1:0] i_ys,
  input  logic [CW-1:0] i_ye,
  output logic [CW-1:0] o_nx,
  output logic [CW-1:0] o_ny,
  output logic          o_last
);

  logic [CW-1:0] r_x;
  logic [CW-1:0] r_y;
  logic [CW-1:0] r_xs;
  logic [CW-1:0] r_xe;
  logic [CW-1:0] r_ye;
  logic          w_row_end;

  assign w_row_end = (r_x == r_xe);
  assign o_last    = w_row_end && (r_y == r_ye);
  assign o_nx      = w_row_end ? r_xs : r_x + 1'b1;
  assign o_ny      = w_row_end ? r_y + 1'b1 : r_y;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_x  <= '0;
      r_y  <= '0;
      r_xs <= '0;
      r_xe <= '0;
      r_ye <= '0;
    end else if (i_start) begin
      r_x  <= i_xs;
      r_y  <= i_ys;
      r_xs <= i_xs;
      r_xe <= i_xe;
      r_ye <= i_ye;
    end else if (i_step) begin
      r_x <= o_nx;
      r_y <= o_ny;
    end
  end

endmodule

// File: rtl/frame_write_ctrl.sv
// Write-port controller for the 1-bit display RAM: runs pixel/line/rect/clear commands
// and arbitrates them against direct NIOS writes.
module frame_write_ctrl #(
  parameter int unsigned IMG_W = frame_pkg::IMG_W,
  parameter int unsigned IMG_H = frame_pkg::IMG_H,
  parameter int unsigned AW    = frame_pkg::AW
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [1:0]    cmd_op,
  input  logic [5:0]    cmd_x0,
  input  logic [5:0]    cmd_y0,
  input  logic [5:0]    cmd_x1,
  input  logic [5:0]    cmd_y1,
  input  logic          cmd_color,
  input  logic          dir_wren,
  input  logic [AW-1:0] dir_addr,
  input  logic          dir_data,
  output logic          dir_ready,
  output logic          busy,
  output logic          done,
  output logic          dir_drop,
  output logic          wren,
  output logic [AW-1:0] wraddress,
  output logic          data
);

  import frame_pkg::*;

  state_t        r_state;
  state_t        w_state_d;
  logic          r_wren;
  logic [AW-1:0] r_wraddress;
  logic          r_data;
  logic          r_dir_drop;
  logic          r_color;

  logic [CW-1:0] w_xs;
  logic [CW-1:0] w_xe;
  logic [CW-1:0] w_ys;
  logic [CW-1:0] w_ye;
  logic [CW-1:0] w_nx;
  logic [CW-1:0] w_ny;
  logic          w_last;
  logic          w_start;
  logic          w_step;
  logic          w_wr_en;
  logic [AW-1:0] w_wr_addr;
  logic          w_wr_data;
  logic          w_drop_set;

  // Normalised bounding box of the command currently on the input.
  always_comb begin
    w_xs = min_c(cmd_x0, cmd_x1);
    w_xe = max_c(cmd_x0, cmd_x1);
    w_ys = min_c(cmd_y0, cmd_y1);
    w_ye = max_c(cmd_y0, cmd_y1);
    unique case (cmd_op)
      OP_SET_PIXEL: begin
        w_xs = cmd_x0;
        w_xe = cmd_x0;
        w_ys = cmd_y0;
        w_ye = cmd_y0;
      end
      OP_HLINE: begin
        w_ys = cmd_y0;
        w_ye = cmd_y0;
      end
      OP_RECT: ;
      OP_CLEAR: begin
        w_xs = '0;
        w_xe = CW'(IMG_W - 1);
        w_ys = '0;
        w_ye = CW'(IMG_H - 1);
      end
      default: ;
    endcase
  end

  rect_scanner #(
    .CW(CW)
  ) u_scanner (
    .i_clk   (clk),
    .i_rst_n (reset),
    .i_start (w_start),
    .i_step  (w_step),
    .i_xs    (w_xs),
    .i_xe    (w_xe),
    .i_ys    (w_ys),
    .i_ye    (w_ye),
    .o_nx    (w_nx),
    .o_ny    (w_ny),
    .o_last  (w_last)
  );

  assign dir_ready = (r_state == StIdle);
  assign cmd_ready = (r_state == StIdle) && !dir_wren;
  assign busy      = (r_state != StIdle);
  assign done      = (r_state == StFinish);
  assign dir_drop  = r_dir_drop;
  assign wren      = r_wren;
  assign wraddress = r_wraddress;
  assign data      = r_data;

  // The first pixel is issued in the acceptance cycle; after that the scanner holds the
  // pixel last issued, so DRAW issues its successor until the held pixel is the last one.
  always_comb begin
    w_state_d  = r_state;
    w_start    = 1'b0;
    w_step     = 1'b0;
    w_wr_en    = 1'b0;
    w_wr_addr  = r_wraddress;
    w_wr_data  = r_data;
    w_drop_set = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (dir_wren) begin
          w_wr_en   = 1'b1;
          w_wr_addr = dir_addr;
          w_wr_data = dir_data;
        end else if (cmd_valid) begin
          w_start   = 1'b1;
          w_wr_en   = 1'b1;
          w_wr_addr = AW'({w_ys, w_xs});
          w_wr_data = cmd_color;
          w_state_d = StDraw;
        end
      end
      StDraw: begin
        w_drop_set = dir_wren;
        if (w_last) begin
          w_state_d = StFinish;
        end else begin
          w_step    = 1'b1;
          w_wr_en   = 1'b1;
          w_wr_addr = AW'({w_ny, w_nx});
          w_wr_data = r_color;
        end
      end
      StFinish: begin
        w_drop_set = dir_wren;
        w_state_d  = StIdle;
      end
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state     <= StIdle;
      r_wren      <= 1'b0;
      r_wraddress <= '0;
      r_data      <= 1'b0;
      r_dir_drop  <= 1'b0;
      r_color     <= 1'b0;
    end else begin
      r_state    <= w_state_d;
      r_wren     <= w_wr_en;
      r_dir_drop <= r_dir_drop | w_drop_set;
      if (w_wr_en) begin
        r_wraddress <= w_wr_addr;
        r_data      <= w_wr_data;
      end
      if (w_start) begin
        r_color <= cmd_color;
      end
    end
  end

endmodule

// File: tb/tb_frame_write_ctrl.sv
// Directed bench for frame_write_ctrl: drives on the falling edge, samples just after it.
module tb_frame_write_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [1:0]  cmd_op = 2'b00;
  logic [5:0]  cmd_x0 = '0;
  logic [5:0]  cmd_y0 = '0;
  logic [5:0]  cmd_x1 = '0;
  logic [5:0]  cmd_y1 = '0;
  logic        cmd_color = 1'b0;
  logic        dir_wren = 1'b0;
  logic [11:0] dir_addr = '0;
  logic        dir_data = 1'b0;
  logic        dir_ready;
  logic        busy;
  logic        done;
  logic        dir_drop;
  logic        wren;
  logic [11:0] wraddress;
  logic        data;

  int n_pass  = 0;
  int n_total = 0;

  logic [11:0] wq[$];
  int nwr, ndone, nbusy, first_idx, done_idx, bad_data, bad_seq, cnt_w, cnt_d;
  logic [11:0] rect_exp [6];

  always #5 clk = ~clk;

  frame_write_ctrl dut (
    .clk       (clk),
    .reset     (reset),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_x0    (cmd_x0),
    .cmd_y0    (cmd_y0),
    .cmd_x1    (cmd_x1),
    .cmd_y1    (cmd_y1),
    .cmd_color (cmd_color),
    .dir_wren  (dir_wren),
    .dir_addr  (dir_addr),
    .dir_data  (dir_data),
    .dir_ready (dir_ready),
    .busy      (busy),
    .done      (done),
    .dir_drop  (dir_drop),
    .wren      (wren),
    .wraddress (wraddress),
    .data      (data)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Present a command for one cycle; returns at the first falling edge after acceptance.
  task automatic issue(input logic [1:0] op, input logic [5:0] x0, input logic [5:0] y0,
                       input logic [5:0] x1, input logic [5:0] y1, input logic color);
    cmd_op = op; cmd_x0 = x0; cmd_y0 = y0; cmd_x1 = x1; cmd_y1 = y1; cmd_color = color;
    cmd_valid = 1'b1;
    #1;
    check("cmd_ready_idle", {31'd0, cmd_ready}, 32'd1);
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  // Watch one command from the cycle after acceptance until busy drops.
  task automatic collect(input int budget, input int poke, input logic exp_color);
    int  i;
    bit  fin;
    i = 0; fin = 1'b0;
    wq.delete();
    nwr = 0; ndone = 0; nbusy = 0; first_idx = -1; done_idx = -1; bad_data = 0;
    while (!fin && i < budget) begin
      if (!busy && i > 0) begin
        fin = 1'b1;
      end else begin
        if (wren) begin
          if (first_idx < 0) first_idx = i;
          wq.push_back(wraddress);
          nwr++;
          if (data !== exp_color) bad_data++;
        end
        if (done) begin
          ndone++;
          done_idx = i;
        end
        if (busy) nbusy++;
        if (i == poke) begin
          dir_wren = 1'b1; dir_addr = 12'hFFF; dir_data = 1'b0;
          #1;
          check("dir_ready_in_draw", {31'd0, dir_ready}, 32'd0);
        end else begin
          dir_wren = 1'b0;
        end
        @(negedge clk);
        i++;
      end
    end
    dir_wren = 1'b0;
    check("cmd_completes_in_budget", {31'd0, fin}, 32'd1);
  endtask

  initial begin
    rect_exp[0] = 12'h088; rect_exp[1] = 12'h089; rect_exp[2] = 12'h08A;
    rect_exp[3] = 12'h0C8; rect_exp[4] = 12'h0C9; rect_exp[5] = 12'h0CA;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_wren", {31'd0, wren}, 32'd0);
    check("rst_wraddress", {20'd0, wraddress}, 32'd0);
    check("rst_data", {31'd0, data}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_dir_drop", {31'd0, dir_drop}, 32'd0);
    reset = 1'b1;
    @(negedge clk);
    #1;
    check("idle_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    check("idle_dir_ready", {31'd0, dir_ready}, 32'd1);
    @(negedge clk);

    // SET_PIXEL (5,3) colour 1
    issue(2'b00, 6'd5, 6'd3, 6'd0, 6'd0, 1'b1);
    check("px_wren", {31'd0, wren}, 32'd1);
    check("px_addr", {20'd0, wraddress}, 32'h0C5);
    check("px_data", {31'd0, data}, 32'd1);
    check("px_busy", {31'd0, busy}, 32'd1);
    check("px_done_early", {31'd0, done}, 32'd0);
    @(negedge clk);
    check("px_fin_wren", {31'd0, wren}, 32'd0);
    check("px_fin_done", {31'd0, done}, 32'd1);
    check("px_fin_busy", {31'd0, busy}, 32'd1);
    @(negedge clk);
    check("px_idle_done", {31'd0, done}, 32'd0);
    check("px_idle_busy", {31'd0, busy}, 32'd0);
    check("px_addr_hold", {20'd0, wraddress}, 32'h0C5);

    // RECT with reversed x
    issue(2'b10, 6'd10, 6'd2, 6'd8, 6'd3, 1'b1);
    collect(50, -1, 1'b1);
    check("rect_writes", nwr, 6);
    for (int k = 0; k < 6 && k < wq.size(); k++) begin
      check($sformatf("rect_addr%0d", k), {20'd0, wq[k]}, {20'd0, rect_exp[k]});
    end
    check("rect_done_count", ndone, 1);
    check("rect_done_pos", done_idx, 6);
    check("rect_first_lat", first_idx, 0);
    check("rect_bad_data", bad_data, 0);
    @(negedge clk);

    // Full CLEAR with colour 0
    issue(2'b11, 6'd17, 6'd9, 6'd3, 6'd1, 1'b0);
    collect(5000, -1, 1'b0);
    bad_seq = 0;
    foreach (wq[k]) if (wq[k] !== 12'(k)) bad_seq++;
    check("clr_writes", nwr, 4096);
    check("clr_addr_seq", bad_seq, 0);
    check("clr_busy_cycles", nbusy, 4097);
    check("clr_done_count", ndone, 1);
    check("clr_done_pos", done_idx, 4096);
    check("clr_bad_data", bad_data, 0);
    @(negedge clk);

    // Reset mid-CLEAR
    issue(2'b11, 6'd0, 6'd0, 6'd0, 6'd0, 1'b1);
    repeat (99) @(negedge clk);
    check("midclr_busy_before", {31'd0, busy}, 32'd1);
    reset = 1'b0;
    @(negedge clk);
    check("midclr_rst_wren", {31'd0, wren}, 32'd0);
    check("midclr_rst_busy", {31'd0, busy}, 32'd0);
    check("midclr_rst_addr", {20'd0, wraddress}, 32'd0);
    reset = 1'b1;
    cnt_w = 0; cnt_d = 0;
    repeat (10) begin
      @(negedge clk);
      if (wren) cnt_w++;
      if (done) cnt_d++;
    end
    check("midclr_no_writes", cnt_w, 0);
    check("midclr_no_done", cnt_d, 0);
    #1;
    check("midclr_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    @(negedge clk);

    // Direct write and command in the same IDLE cycle
    dir_wren = 1'b1; dir_addr = 12'h123; dir_data = 1'b1;
    cmd_op = 2'b00; cmd_x0 = 6'd1; cmd_y0 = 6'd1; cmd_color = 1'b0; cmd_valid = 1'b1;
    #1;
    check("arb_cmd_ready_blocked", {31'd0, cmd_ready}, 32'd0);
    check("arb_dir_ready", {31'd0, dir_ready}, 32'd1);
    @(negedge clk);
    dir_wren = 1'b0;
    check("arb_dir_wren", {31'd0, wren}, 32'd1);
    check("arb_dir_addr", {20'd0, wraddress}, 32'h123);
    check("arb_dir_data", {31'd0, data}, 32'd1);
    #1;
    check("arb_cmd_ready_next", {31'd0, cmd_ready}, 32'd1);
    @(negedge clk);
    cmd_valid = 1'b0;
    check("arb_px_wren", {31'd0, wren}, 32'd1);
    check("arb_px_addr", {20'd0, wraddress}, 32'h041);
    check("arb_px_data", {31'd0, data}, 32'd0);
    @(negedge clk);
    check("arb_px_done", {31'd0, done}, 32'd1);
    check("arb_no_drop", {31'd0, dir_drop}, 32'd0);
    @(negedge clk);

    // Direct write during a full-width HLINE is dropped
    issue(2'b01, 6'd0, 6'd7, 6'd63, 6'd50, 1'b1);
    collect(200, 5, 1'b1);
    bad_seq = 0;
    foreach (wq[k]) if (wq[k] !== 12'(12'h1C0 + k)) bad_seq++;
    check("hl_writes", nwr, 64);
    check("hl_addr_seq", bad_seq, 0);
    check("hl_done_count", ndone, 1);
    check("hl_drop_after_done", {31'd0, dir_drop}, 32'd1);
    repeat (3) @(negedge clk);
    check("hl_drop_sticky", {31'd0, dir_drop}, 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/frame_write_ctrl.md
Name: frame_write_ctrl

Overview:
Write-port controller for the 64x64 1-bit display RAM (address = y*64 + x, 12 bits). It sequences drawing commands from the NIOS: set pixel, horizontal line, filled rectangle and clear. It also arbitrates them against raw direct writes from the NIOS. Its outputs drive the RAM's wren/wraddress/data inputs; the VGA read side is unaffected.

Parameters:
IMG_W, 64, image width in pixels (power of two; address = y*IMG_W + x)
IMG_H, 64, image height in pixels
AW, 12, RAM address width (log2(IMG_W*IMG_H))

Ports:
clk  in  1  system clock (same domain as RAM write port)
reset  in  1  synchronous, active-low reset
cmd_valid  in  1  command request
cmd_ready  out  1  command accepted when cmd_valid & cmd_ready
cmd_op  in  2  00 SET_PIXEL, 01 HLINE, 10 RECT, 11 CLEAR
cmd_x0  in  6  start x
cmd_y0  in  6  start y
cmd_x1  in  6  end x (HLINE/RECT)
cmd_y1  in  6  end y (RECT)
cmd_color  in  1  pixel value to write
dir_wren  in  1  direct write request
dir_addr  in  AW  direct write address
dir_data  in  1  direct write data
dir_ready  out  1  direct write accepted when dir_wren & dir_ready
busy  out  1  engine executing a command
done  out  1  one-cycle pulse after the last write of a command
dir_drop  out  1  sticky: a dir_wren arrived while dir_ready=0; cleared by reset only
wren  out  1  RAM write enable
wraddress  out  AW  RAM write address
data  out  1  RAM write data

Behaviour:
- Reset (reset=0 at clk edge): state IDLE; wren=0, wraddress=0, data=0, busy=0, done=0, dir_drop=0. Applies mid-command: the command is abandoned, no done pulse, and no further writes occur.
- Registered outputs: wren/wraddress/data are flops; every write appears the cycle after its decision.
- States: IDLE, DRAW, FINISH.
- In IDLE:
  - dir_ready=1.
  - cmd_ready = ~dir_wren. A direct write has priority in the same cycle; the command waits.
  - dir_wren → next cycle wren=1, wraddress=dir_addr, data=dir_data.
  - Accepted command → latch the operands and go to DRAW.
- Operand latching at acceptance:
  - Coordinates are normalized: xs=min(x0,x1), xe=max(x0,x1), ys=min(y0,y1), ye=max(y0,y1).
  - SET_PIXEL: xs=xe=x0, ys=ye=y0.
  - HLINE: ys=ye=y0.
  - CLEAR: xs=0, xe=IMG_W-1, ys=0, ye=IMG_H-1; the x/y inputs are ignored.
- DRAW:
  - One write per cycle; x is the inner loop (xs..xe), y the outer loop (ys..ye).
  - wraddress = {y,x}; data = latched color.
  - The first write appears 1 cycle after acceptance (wren high that cycle).
  - Total writes = (xe-xs+1)*(ye-ys+1). CLEAR takes 4096 cycles.
  - Counters are 6 bits, so there is no wrap past 63; the loop terminates on equality with xe/ye.
  - busy=1 from the cycle after acceptance through FINISH.
  - dir_ready=0 and cmd_ready=0. A dir_wren in this state sets dir_drop and writes nothing.
- FINISH (cycle after the last write):
  - wren=0, done=1 for exactly one cycle, busy=1.
  - Next state IDLE, where busy=0.
- Back-to-back commands: earliest next acceptance is in the IDLE cycle after FINISH.
- When no write is issued: wren=0. wraddress/data hold their last values.

Decomposition:
- Shared package frame_pkg:
  - IMG_W/IMG_H/AW constants.
  - Opcode constants OP_SET_PIXEL, OP_HLINE, OP_RECT, OP_CLEAR.
  - State encoding.
- One natural sub-module: rect_scanner. It takes xs/xe/ys/ye with a start pulse, steps x/y, and flags last. The top holds the FSM, arbitration and output registers.

Test Plan:
- Reset low mid-CLEAR at cycle 100, then release → wren=0 from the next cycle, no done pulse, cmd_ready=1 again in IDLE.
- SET_PIXEL x0=5,y0=3,color=1 → exactly one write, wraddress=0x0C5, data=1, one cycle after acceptance; done 1 cycle later.
- RECT x0=10,y0=2,x1=8,y1=3 (reversed x) → 6 writes in order 0x088,0x089,0x08A,0x0C8,0x0C9,0x0CA, then a single done pulse.
- CLEAR color=0 → 4096 consecutive writes, addresses 0x000..0xFFF, busy high for 4097 cycles, done once.
- dir_wren and cmd_valid in the same IDLE cycle → direct write issued first, cmd_ready=0 that cycle, command accepted the following cycle.
- dir_wren during HLINE x0=0..x1=63 → write ignored, dir_drop=1 and it stays 1 after done.
